// File: rtl/rs_pkg.sv
// ----------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the psum accumulation buffer: word width, layer
// limits, derived counter/address widths, the accumulator FSM state type and
// the buffer address helper.
//
// Optional feature macro used by the top: PSUM_RELU_EN (see psum_accum_buffer).
// ----------------------------------------------------------------------------
package rs_pkg;

  localparam int PSUM_W   = 16;
  localparam int MAX_CH   = 8;
  localparam int MAX_OUT  = 64;
  localparam int MAX_PASS = 15;

  localparam int CH_W   = $clog2(MAX_CH);
  localparam int IDX_W  = $clog2(MAX_OUT);
  localparam int NOUT_W = $clog2(MAX_OUT + 1);
  localparam int DEPTH  = MAX_CH * MAX_OUT;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } accum_state_t;

  typedef logic [PSUM_W-1:0] psum_t;

  // Flat register-file address of pixel idx in channel ch.
  function automatic logic [ADDR_W-1:0] buf_addr(input logic [CH_W-1:0]  ch,
                                                 input logic [IDX_W-1:0] idx);
    return ADDR_W'(ch) * ADDR_W'(MAX_OUT) + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/psum_buffer.sv
// ----------------------------------------------------------------------------
// psum_buffer
// MAX_CH*MAX_OUT x PSUM_W register file holding the ofmap being accumulated.
// One asynchronous read port and one synchronous write port, so the owner can
// read-modify-write one word per cycle. Contents are not reset: the first
// accumulation pass always overwrites every word that is later read.
//
// Ports:
//   clk    in  1       clock, rising edge
//   we     in  1       write enable
//   waddr  in  ADDR_W  write address (ch*MAX_OUT+idx)
//   wdata  in  PSUM_W  write data
//   raddr  in  ADDR_W  read address
//   rdata  out PSUM_W  read data (combinational)
// ----------------------------------------------------------------------------
import rs_pkg::*;

module psum_buffer (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  psum_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output psum_t             rdata
);

  psum_t mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/psum_accum_buffer.sv
// ----------------------------------------------------------------------------
// psum_accum_buffer
// Sits downstream of the PE array. After a valid configuration it accepts
// cfg_num_pass passes of psum words (pixel index fastest, then channel, then
// pass), accumulates them in psum_buffer with wrap-around arithmetic, then
// streams the ofmap out channel-major / pixel-minor on a valid/ready port.
//
// Optional feature: define PSUM_RELU_EN to clamp negative output words to 0
// on the way out (the stored accumulation is unchanged).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cfg_valid/num_ch/num_out/num_pass   layer configuration (IDLE only)
//   cfg_err                      1-cycle pulse when a configuration is rejected
//   in_valid/in_ready/in_data    psum input stream
//   out_valid/out_ready/out_data ofmap output stream
//   out_ch/out_idx/out_last      position of out_data, last-word marker
//   busy                         high while accumulating or draining
//   done                         1-cycle pulse after the last output handshake
// ----------------------------------------------------------------------------
import rs_pkg::*;

module psum_accum_buffer (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [3:0]        cfg_num_ch,
  input  logic [NOUT_W-1:0] cfg_num_out,
  input  logic [3:0]        cfg_num_pass,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  psum_t             in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output psum_t             out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  function automatic psum_t relu_f(input psum_t raw);
`ifdef PSUM_RELU_EN
    return raw[PSUM_W-1] ? {PSUM_W{1'b0}} : raw;
`else
    return raw;
`endif
  endfunction

  accum_state_t      state_q, state_d;
  logic [3:0]        num_ch_q, num_ch_d;
  logic [NOUT_W-1:0] num_out_q, num_out_d;
  logic [3:0]        num_pass_q, num_pass_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [3:0]        pass_q, pass_d;
  logic              drained_q, drained_d;
  logic              cfg_err_q, cfg_err_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  psum_t             out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;

  logic              cfg_ok;
  logic              idx_last, ch_last, pass_last;
  logic [ADDR_W-1:0] buf_addr_cur;
  logic              buf_we;
  psum_t             buf_wdata;
  psum_t             buf_rdata;

  assign cfg_ok = (cfg_num_ch   != 4'd0) && (cfg_num_ch   <= 4'(MAX_CH)) &&
                  (cfg_num_out  != {NOUT_W{1'b0}}) && (cfg_num_out <= NOUT_W'(MAX_OUT)) &&
                  (cfg_num_pass != 4'd0) && (cfg_num_pass <= 4'(MAX_PASS));

  assign idx_last  = ({1'b0, idx_q} == (num_out_q - NOUT_W'(1)));
  assign ch_last   = ({1'b0, ch_q}  == (num_ch_q - 4'd1));
  assign pass_last = (pass_q == (num_pass_q - 4'd1));

  // The same counters address the RMW during ACCUM and the read-out during
  // DRAIN; they are all back at zero when ACCUM finishes.
  assign buf_addr_cur = buf_addr(ch_q, idx_q);
  assign buf_wdata    = (pass_q == 4'd0) ? in_data : (buf_rdata + in_data);

  psum_buffer u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr_cur),
    .wdata (buf_wdata),
    .raddr (buf_addr_cur),
    .rdata (buf_rdata)
  );

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d     = state_q;
    num_ch_d    = num_ch_q;
    num_out_d   = num_out_q;
    num_pass_d  = num_pass_q;
    idx_d       = idx_q;
    ch_d        = ch_q;
    pass_d      = pass_q;
    drained_d   = drained_q;
    cfg_err_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    buf_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_ok) begin
            state_d    = ACCUM;
            num_ch_d   = cfg_num_ch;
            num_out_d  = cfg_num_out;
            num_pass_d = cfg_num_pass;
            idx_d      = {IDX_W{1'b0}};
            ch_d       = {CH_W{1'b0}};
            pass_d     = 4'd0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCUM: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (idx_last) begin
            idx_d = {IDX_W{1'b0}};
            if (ch_last) begin
              ch_d = {CH_W{1'b0}};
              if (pass_last) begin
                pass_d    = 4'd0;
                drained_d = 1'b0;
                state_d   = DRAIN;
              end else begin
                pass_d = pass_q + 4'd1;
              end
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          buf_we = 1'b0;
        end
      end

      DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          state_d     = DONE;
          out_valid_d = 1'b0;
          out_data_d  = {PSUM_W{1'b0}};
          out_ch_d    = {CH_W{1'b0}};
          out_idx_d   = {IDX_W{1'b0}};
          out_last_d  = 1'b0;
        end else if (!drained_q && (!out_valid_q || out_ready)) begin
          // Output register is empty or being consumed: load the next word.
          out_valid_d = 1'b1;
          out_data_d  = relu_f(buf_rdata);
          out_ch_d    = ch_q;
          out_idx_d   = idx_q;
          out_last_d  = idx_last && ch_last;
          if (idx_last) begin
            idx_d = {IDX_W{1'b0}};
            if (ch_last) begin
              ch_d      = {CH_W{1'b0}};
              drained_d = 1'b1;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d == ACCUM) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      num_ch_q    <= 4'd0;
      num_out_q   <= {NOUT_W{1'b0}};
      num_pass_q  <= 4'd0;
      idx_q       <= {IDX_W{1'b0}};
      ch_q        <= {CH_W{1'b0}};
      pass_q      <= 4'd0;
      drained_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {PSUM_W{1'b0}};
      out_ch_q    <= {CH_W{1'b0}};
      out_idx_q   <= {IDX_W{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_ch_q    <= num_ch_d;
      num_out_q   <= num_out_d;
      num_pass_q  <= num_pass_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      pass_q      <= pass_d;
      drained_q   <= drained_d;
      cfg_err_q   <= cfg_err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// ----------------------------------------------------------------------------
// tb_psum_accum_buffer
// Directed scoreboard bench for psum_accum_buffer. Stimulus pushes expected
// ofmap words into a queue; a monitor pops and compares on each output
// handshake and checks that outputs hold during stalls.
// ----------------------------------------------------------------------------
module tb_psum_accum_buffer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [3:0]  cfg_num_ch;
  logic [6:0]  cfg_num_out;
  logic [3:0]  cfg_num_pass;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_ch;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  ch;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  psum_accum_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_num_ch   (cfg_num_ch),
    .cfg_num_out  (cfg_num_out),
    .cfg_num_pass (cfg_num_pass),
    .cfg_err      (cfg_err),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [2:0] c, input logic [5:0] i,
                      input logic l);
    exp_t e;
    e.data = d; e.ch = c; e.idx = i; e.last = l;
    sb.push_back(e);
  endtask

  task automatic cfg(input logic [3:0] c, input logic [6:0] o, input logic [3:0] p);
    cfg_valid = 1'b1; cfg_num_ch = c; cfg_num_out = o; cfg_num_pass = p;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input logic [3:0] pat);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 1000) begin
      out_ready = pat[cyc % 4];
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      cyc++;
    end
    out_ready = 1'b1;
    chk("done_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  // Output monitor: scoreboard compare on handshake, hold check during stall.
  initial begin : monitor
    exp_t e;
    logic [26:0] held;
    bit stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_hold", {5'd0, out_valid, out_data, out_ch, out_idx, out_last},
              {5'd0, held});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got data %0h ch %0d idx %0d, expected none",
                     out_data, out_ch, out_idx);
          end else begin
            e = sb.pop_front();
            chk("out_word", {6'd0, out_data, out_ch, out_idx, out_last},
                {6'd0, e.data, e.ch, e.idx, e.last});
          end
          stalled = 1'b0;
        end else if (out_valid) begin
          held    = {out_valid, out_data, out_ch, out_idx, out_last};
          stalled = 1'b1;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; cfg_valid = 1'b0; cfg_num_ch = 4'd0; cfg_num_out = 7'd0;
    cfg_num_pass = 4'd0; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outs", {8'd0, out_data, out_ch, out_idx, out_last, cfg_err, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: two channels of nine pixels, single pass.
    for (int k = 0; k < 18; k++)
      push(16'(k + 1), 3'(k / 9), 6'(k % 9), (k == 17));
    cfg(4'd2, 7'd9, 4'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 18; k++) send(16'(k + 1));
    in_valid = 1'b0;
    chk("t1_in_ready_drain", {31'd0, in_ready}, 32'd0);
    wait_done(4'b1111);

    // 2: three passes of {1,2,3,4}; a config during ACCUM is ignored.
    for (int k = 0; k < 4; k++) push(16'(3 * (k + 1)), 3'd0, 6'(k), (k == 3));
    cfg(4'd1, 7'd4, 4'd3);
    cfg(4'd0, 7'd4, 4'd1);
    chk("t2_cfg_ignored", {31'd0, cfg_err}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++) send(16'(k + 1));
    in_valid = 1'b0;
    wait_done(4'b1111);

    // 3: modular wrap, then negative value (clamped when ReLU is built in).
    push(16'h0001, 3'd0, 6'd0, 1'b1);
    cfg(4'd1, 7'd1, 4'd2);
    send(16'hFFFF);
    send(16'h0002);
    in_valid = 1'b0;
    wait_done(4'b1111);
`ifdef PSUM_RELU_EN
    push(16'h0000, 3'd0, 6'd0, 1'b1);
`else
    push(16'hFFF0, 3'd0, 6'd0, 1'b1);
`endif
    cfg(4'd1, 7'd1, 4'd1);
    send(16'hFFF0);
    in_valid = 1'b0;
    wait_done(4'b1111);

    // 4: rejected configurations.
    cfg(4'd0, 7'd4, 4'd1);
    chk("t4a_cfg_err", {31'd0, cfg_err}, 32'd1);
    chk("t4a_busy", {31'd0, busy}, 32'd0);
    chk("t4a_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t4a_err_pulse", {31'd0, cfg_err}, 32'd0);
    cfg(4'd1, 7'd65, 4'd1);
    chk("t4b_cfg_err", {31'd0, cfg_err}, 32'd1);
    chk("t4b_busy", {31'd0, busy}, 32'd0);
    chk("t4b_in_ready", {31'd0, in_ready}, 32'd0);
    cfg(4'd9, 7'd4, 4'd1);
    chk("t4c_cfg_err", {31'd0, cfg_err}, 32'd1);
    @(posedge clk); #1;
    chk("t4_still_idle", {31'd0, busy}, 32'd0);

    // 5: back-pressure with out_ready 1,0,0,1.
    push(16'd10, 3'd0, 6'd0, 1'b0);
    push(16'd20, 3'd0, 6'd1, 1'b0);
    push(16'd30, 3'd0, 6'd2, 1'b0);
    push(16'd40, 3'd0, 6'd3, 1'b1);
    cfg(4'd1, 7'd4, 4'd1);
    send(16'd10); send(16'd20); send(16'd30); send(16'd40);
    in_valid = 1'b0;
    wait_done(4'b1001);

    // 6: reset after five words, then a fresh two-pass run.
    cfg(4'd1, 7'd8, 4'd1);
    for (int k = 0; k < 5; k++) send(16'(100 + k));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_outs", {7'd0, out_valid, out_data, out_ch, out_idx, out_last, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    push(16'd11, 3'd0, 6'd0, 1'b0);
    push(16'd22, 3'd0, 6'd1, 1'b0);
    push(16'd33, 3'd1, 6'd0, 1'b0);
    push(16'd44, 3'd1, 6'd1, 1'b1);
    cfg(4'd2, 7'd2, 4'd2);
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    send(16'd10); send(16'd20); send(16'd30); send(16'd40);
    in_valid = 1'b0;
    wait_done(4'b1111);

    repeat (2) @(posedge clk);
    #1;
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
